// File: rtl/aes_key_expand_pkg.sv
// Shared types, S-box table and GF(2^8) helpers for the AES key-expansion engine.
package aes_key_expand_pkg;

    typedef logic [31:0]  ulogic32;
    typedef logic [127:0] ulogic128;
    typedef logic [255:0] ulogic256;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b01,
        KEY_256 = 2'b10
    } key_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXPAND = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] key_nk(input key_mode_e mode);
        case (mode)
            KEY_192: return 4'd6;
            KEY_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] key_nr(input key_mode_e mode);
        case (mode)
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expand_subword.sv
// SubWord: byte-wise S-box substitution of one 32-bit word.
module aes_subword
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subst
);

    assign subst = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key expansion, one word per cycle, with a registered round-key read port.
// Optional AES_KEY_ZEROIZE_EN adds i_zeroize to wipe the key schedule.
//   state     | meaning
//   ST_IDLE   | no valid schedule, waiting for start
//   ST_EXPAND | generating w[i], one word per edge
//   ST_DONE   | schedule complete, round keys readable
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int MAX_WORDS = 60
)
(
    input  logic           clk,
    input  logic           reset,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic           i_zeroize,
`endif
    input  logic [255:0]   i_key,
    input  logic [1:0]     i_key_mode,
    input  logic           i_start,
    output logic           o_key_ready,
    output logic           o_busy,
    output logic [3:0]     o_nr,
    input  logic [3:0]     i_rk_addr,
    output logic [127:0]   o_rk
);

    localparam int IW = $clog2(MAX_WORDS);

    state_e          state;
    key_mode_e       mode;
    ulogic32         w [MAX_WORDS];
    logic [IW-1:0]   idx;
    logic [2:0]      j;
    logic [7:0]      rcon;

    logic            zeroize;
    logic            start_ok;
    logic [3:0]      nk;
    logic [3:0]      nk_start;
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   rk_base;
    ulogic32         prev_word;
    ulogic32         back_word;
    ulogic32         sub_in;
    ulogic32         sub_out;
    ulogic32         temp;
    ulogic32         new_word;

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize = i_zeroize;
`else
    assign zeroize = 1'b0;
`endif

    assign start_ok  = i_start && (i_key_mode != 2'b11) && (state != ST_EXPAND);
    assign nk        = key_nk(mode);
    assign nk_start  = key_nk(key_mode_e'(i_key_mode));
    assign last_idx  = IW'({o_nr + 4'd1, 2'b00} - 6'd1);
    assign rk_base   = IW'({i_rk_addr, 2'b00});
    assign prev_word = w[idx - IW'(1)];
    assign back_word = w[idx - IW'(nk)];
    assign sub_in    = (j == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_subword u_subword (
        .word  (sub_in),
        .subst (sub_out)
    );

    always_comb begin
        temp = prev_word;
        if (j == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && j == 3'd4)
            temp = sub_out;
        new_word = back_word ^ temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode        <= KEY_128;
            o_key_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_nr        <= 4'd0;
            o_rk        <= '0;
            idx         <= '0;
            j           <= 3'd0;
            rcon        <= 8'h00;
            for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
        end else if (zeroize) begin
            state       <= ST_IDLE;
            mode        <= KEY_128;
            o_key_ready <= 1'b0;
            o_busy      <= 1'b0;
            o_nr        <= 4'd0;
            o_rk        <= '0;
            idx         <= '0;
            j           <= 3'd0;
            rcon        <= 8'h00;
            for (int k = 0; k < MAX_WORDS; k++) w[k] <= '0;
        end else begin
            // A restarting schedule must not leak through the read port on the start edge.
            o_rk <= '0;
            if (o_key_ready && !start_ok && i_rk_addr <= o_nr)
                o_rk <= {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        for (int k = 0; k < 8; k++)
                            if (k < int'(nk_start)) w[k] <= i_key[255 - 32*k -: 32];
                        mode        <= key_mode_e'(i_key_mode);
                        o_nr        <= key_nr(key_mode_e'(i_key_mode));
                        idx         <= IW'(nk_start);
                        j           <= 3'd0;
                        rcon        <= 8'h01;
                        o_key_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        state       <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    w[idx] <= new_word;
                    idx    <= idx + IW'(1);
                    j      <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
                    if (j == 3'd0) rcon <= xtime(rcon);
                    if (idx == last_idx) begin
                        state       <= ST_DONE;
                        o_key_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand against a FIPS-197 style reference model.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] i_key;
    logic [1:0]   i_key_mode;
    logic         i_start;
    logic         o_key_ready;
    logic         o_busy;
    logic [3:0]   o_nr;
    logic [3:0]   i_rk_addr;
    logic [127:0] o_rk;
    logic         zeroize;

    always #5 clk = ~clk;

    aes_key_expand #(.MAX_WORDS(60)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef AES_KEY_ZEROIZE_EN
        .i_zeroize   (zeroize),
`endif
        .i_key       (i_key),
        .i_key_mode  (i_key_mode),
        .i_start     (i_start),
        .o_key_ready (o_key_ready),
        .o_busy      (o_busy),
        .o_nr        (o_nr),
        .i_rk_addr   (i_rk_addr),
        .o_rk        (o_rk)
    );

    typedef struct {
        logic [127:0] rk;
        int           addr;
    } rd_t;

    rd_t         sb_q[$];
    logic        rd_req;
    int          n_cmp;
    int          n_bad;
    logic [7:0]  sb_tab [256];
    logic [31:0] m_w [60];
    int          m_nr;
    bit          m_ready;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    function automatic void chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] t);
        return {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
    endfunction

    function automatic void model_expand(input logic [255:0] key, input logic [1:0] mode);
        int nk, total;
        logic [31:0] t;
        logic [7:0] rc;
        nk    = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
        m_nr  = nk + 6;
        total = 4 * (m_nr + 1);
        for (int k = 0; k < 60; k++) m_w[k] = '0;
        for (int k = 0; k < nk; k++) m_w[k] = key[255 - 32*k -: 32];
        for (int k = nk; k < total; k++) begin
            t = m_w[k-1];
            if (k % nk == 0) begin
                rc = 8'h01;
                for (int p = 1; p < k / nk; p++) rc = gmul(rc, 8'h02);
                t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && k % nk == 4) begin
                t = sub_w(t);
            end
            m_w[k] = m_w[k-nk] ^ t;
        end
    endfunction

    function automatic logic [127:0] model_rk(input int r);
        if (!m_ready || r > m_nr) return '0;
        return {m_w[4*r], m_w[4*r+1], m_w[4*r+2], m_w[4*r+3]};
    endfunction

    function automatic void rd_push_exp(input int addr, input logic [127:0] exp);
        rd_t e;
        i_rk_addr = 4'(addr);
        rd_req    = 1'b1;
        e.rk      = exp;
        e.addr    = addr;
        sb_q.push_back(e);
    endfunction

    function automatic void rd_push(input int addr);
        rd_push_exp(addr, model_rk(addr));
    endfunction

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            rd_push(a);
        end
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_one(input int addr, input logic [127:0] exp);
        @(negedge clk);
        rd_push_exp(addr, exp);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Starts an expansion, reads back zeros while it runs, and returns edges-to-ready.
    task automatic do_start(input logic [255:0] key, input logic [1:0] mode,
                            input int pulse_at, output int lat);
        @(negedge clk);
        i_key      = key;
        i_key_mode = mode;
        i_start    = 1'b1;
        m_ready    = 1'b0;
        rd_push($urandom_range(0, 15));
        @(negedge clk);
        i_start = 1'b0;
        lat     = 1;
        chk_int("busy_after_start", int'(o_busy), 1);
        chk_int("ready_after_start", int'(o_key_ready), 0);
        while (o_key_ready !== 1'b1 && lat < 100) begin
            if (lat + 1 == pulse_at) begin
                i_start    = 1'b1;
                i_key_mode = 2'b10;
                i_key      = {8{$urandom}};
            end
            rd_push($urandom_range(0, 15));
            @(negedge clk);
            i_start = 1'b0;
            lat++;
        end
        rd_req     = 1'b0;
        i_key_mode = mode;
        model_expand(key, mode);
        m_ready = 1'b1;
        chk_int("busy_at_ready", int'(o_busy), 0);
        chk_int("nr", int'(o_nr), m_nr);
    endtask

    initial begin : monitor
        rd_t e;
        forever begin
            @(posedge clk);
            if (rd_req === 1'b1) begin
                #1;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got read with no expected entry, o_rk %h", o_rk);
                end else begin
                    e = sb_q.pop_front();
                    chk128($sformatf("rk[%0d]", e.addr), o_rk, e.rk);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;
        logic [1:0] md;
        logic [255:0] rk_key;
        n_cmp = 0;
        n_bad = 0;
        build_sbox();
        reset = 1'b1; i_key = '0; i_key_mode = 2'b00; i_start = 1'b0;
        i_rk_addr = 4'd0; rd_req = 1'b0; zeroize = 1'b0; m_ready = 1'b0; m_nr = 0;
        repeat (3) @(negedge clk);
        chk_int("rst_ready", int'(o_key_ready), 0);
        chk_int("rst_busy", int'(o_busy), 0);
        chk_int("rst_nr", int'(o_nr), 0);
        chk128("rst_rk", o_rk, '0);
        reset = 1'b0;

        // Reserved mode from IDLE: nothing moves.
        @(negedge clk);
        i_key = K256; i_key_mode = 2'b11; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        chk_int("m11_idle_ready", int'(o_key_ready), 0);
        chk_int("m11_idle_busy", int'(o_busy), 0);
        chk_int("m11_idle_nr", int'(o_nr), 0);

        do_start(K128, 2'b00, 0, lat);
        chk_int("lat128", lat, 41);
        read_one(1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_one(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_one(11, 128'h0);
        read_all();

        do_start(K192, 2'b01, 0, lat);
        chk_int("lat192", lat, 47);
        read_one(12, 128'he98ba06f448c773c8ecc720401002202);
        read_all();

        do_start(K256, 2'b10, 0, lat);
        chk_int("lat256", lat, 53);
        read_one(14, 128'hfe4890d1e6188d0b046df344706c631e);
        read_all();

        // Reserved mode from DONE: schedule and read port unaffected.
        @(negedge clk);
        i_key = K128; i_key_mode = 2'b11; i_start = 1'b1;
        rd_push(3);
        @(negedge clk);
        i_start = 1'b0; rd_req = 1'b0;
        chk_int("m11_done_ready", int'(o_key_ready), 1);
        chk_int("m11_done_busy", int'(o_busy), 0);
        chk_int("m11_done_nr", int'(o_nr), 14);

        // Restart from DONE with a stray start at edge 20.
        do_start(K128, 2'b00, 20, lat);
        chk_int("lat128_pulse", lat, 41);
        read_one(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_all();

        // Reset during edge 25 of a 256-bit expansion.
        @(negedge clk);
        i_key = K256; i_key_mode = 2'b10; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (23) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_int("midrst_ready", int'(o_key_ready), 0);
        chk_int("midrst_busy", int'(o_busy), 0);
        chk_int("midrst_nr", int'(o_nr), 0);
        chk128("midrst_rk", o_rk, '0);
        m_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        read_all();
        do_start(K128, 2'b00, 0, lat);
        chk_int("lat128_after_rst", lat, 41);
        read_one(1, 128'ha0fafe1788542cb123a339392a6c7605);
        read_all();

        for (int n = 0; n < 8; n++) begin
            md     = 2'($urandom_range(0, 2));
            rk_key = {8{$urandom}};
            for (int b = 0; b < 8; b++) rk_key[32*b +: 32] = $urandom;
            do_start(rk_key, md, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0, lat);
            chk_int($sformatf("lat_rand%0d", n), lat, 4 * (m_nr + 1) - (m_nr - 6) + 1);
            read_all();
        end

`ifdef AES_KEY_ZEROIZE_EN
        @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        m_ready = 1'b0;
        chk_int("zero_ready", int'(o_key_ready), 0);
        chk_int("zero_busy", int'(o_busy), 0);
        chk_int("zero_nr", int'(o_nr), 0);
        chk128("zero_rk", o_rk, '0);
        read_all();
        do_start(K192, 2'b01, 0, lat);
        chk_int("lat192_zero", lat, 47);
        @(negedge clk);
        zeroize = 1'b1; i_key = K128; i_key_mode = 2'b00; i_start = 1'b1;
        @(negedge clk);
        zeroize = 1'b0; i_start = 1'b0;
        m_ready = 1'b0;
        chk_int("zero_start_busy", int'(o_busy), 0);
        chk_int("zero_start_ready", int'(o_key_ready), 0);
        @(negedge clk);
        chk_int("zero_start_idle_busy", int'(o_busy), 0);
        chk_int("zero_start_idle_nr", int'(o_nr), 0);
        read_all();
`endif

        repeat (2) @(negedge clk);
        chk_int("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

- Iterative AES key-expansion engine; slave side of the KeyBus.
- Accepts a 128/192/256-bit cipher key and generates all round keys, one 32-bit word per cycle, into an internal word array.
- Raises `o_key_ready` when expansion completes, then serves round keys to the downstream cipher core through a registered read port.

## Interface
Parameters:
- `MAX_WORDS`, 60, word-array depth (4·(14+1), sized for AES-256).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `i_key` in 256: cipher key, MSB-aligned; w[0] = `i_key[255:224]`. 128-bit keys use `[255:128]`, 192-bit keys use `[255:64]`.
- `i_key_mode` in 2: 00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = reserved.
- `i_start` in 1: one-cycle request to start an expansion.
- `o_key_ready` out 1: round keys valid; held high until the next start or reset.
- `o_busy` out 1: expansion in progress.
- `o_nr` out 4: round count Nr = 10/12/14 for the latched mode.
- `i_rk_addr` in 4: round-key index 0..Nr.
- `o_rk` out 128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.

## Operation
- FSM states and transitions:
  - IDLE → EXPAND on `i_start` with a legal mode.
  - EXPAND → DONE after the last word is written.
  - DONE → EXPAND on `i_start` with a legal mode.
- `i_start` with mode 11 is ignored in every state; no output changes.
- `i_start` during EXPAND is ignored.
- Start edge actions:
  - Load Nk (4/6/8) key words into w[0..Nk-1].
  - Latch mode and Nr; set i = Nk, j = 0 (i mod Nk), rcon = 8'h01.
  - Clear `o_key_ready`; set `o_busy`.
- Per EXPAND edge, compute one word with temp = w[i-1]:
  - j == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}; rcon ← xtime(rcon) (0x80 → 0x1b).
  - Nk == 8 and j == 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] ^ temp; i++; j wraps at Nk without division.
- After writing w[4·(Nr+1)-1] on the same edge: state ← DONE, `o_key_ready` ← 1, `o_busy` ← 0.
- Read port, registered:
  - `o_rk` ← round key `i_rk_addr` when `o_key_ready` = 1 and `i_rk_addr` ≤ Nr.
  - Otherwise `o_rk` ← 0.

## Timing
- Reset values:
  - State IDLE; `o_key_ready` = 0, `o_busy` = 0, `o_nr` = 0, `o_rk` = 0.
  - Word array cleared; i, j, rcon = 0.
- Reset asserted mid-expansion aborts immediately to the reset values.
- Latency, counted in clock edges from the edge sampling `i_start` to `o_key_ready` high: 41 (128-bit), 47 (192-bit), 53 (256-bit).
- `o_rk` is valid one edge after `i_rk_addr` is presented.
- Restart from DONE drops `o_key_ready` on the start edge; reads return 0 until completion.

## Configuration
- `AES_KEY_ZEROIZE_EN` defined:
  - Adds input `i_zeroize` (1 bit).
  - When asserted, in any state on the next edge: clear the whole word array, `o_key_ready`, `o_busy`, `o_nr`, `o_rk`, and return to IDLE.
  - `i_zeroize` has priority over a simultaneous `i_start`.
- Undefined: port absent; the array retains contents until overwritten by the next expansion.

## Structure
- Shared definitions package holds:
  - Typedefs `ulogic32`, `ulogic128`, `ulogic256`.
  - Key-mode enum KEY_128 = 2'b00, KEY_192 = 2'b01, KEY_256 = 2'b10.
  - FSM state enum.
  - 256-entry S-box constant and `xtime` function.
- One sub-module, `aes_subword`: combinational 4-byte S-box substitution, instantiated once.

## Test plan
- 128-bit, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c → `o_key_ready` at edge 41, `o_nr` = 10; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → ready at edge 47, `o_nr` = 12; rk12 = e98ba06f448c773c8ecc720401002202.
- 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → ready at edge 53, `o_nr` = 14; rk14 = fe4890d1e6188d0b046df344706c631e.
- Mode 11 start → no state change, `o_key_ready` stays 0. `i_start` pulsed at edge 20 of an expansion → ignored, same results. Read `i_rk_addr` = 11 in 128-bit mode → `o_rk` = 0.
- Reset asserted at edge 25 of a 256-bit expansion → all outputs 0 immediately. A new 128-bit start then yields correct keys.
- With `AES_KEY_ZEROIZE_EN`: `i_zeroize` in DONE → `o_key_ready` = 0, all reads return 0. `i_zeroize` and `i_start` on the same edge → IDLE.
